// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the fetch stage: in-order request channel plus response channel.
// A request transfers on a clock edge where imem_req_valid && imem_req_ready; responses carry no ready.
interface fetch_stage_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_resp_valid,
      input  imem_resp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_resp_valid,
      output imem_resp_data
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues credit-limited in-order fetches,
// queues returned words and drives the IF/ID register with stall/redirect handling.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         stall,
   input  logic                         redirect_valid,
   input  logic [31:0]                  redirect_pc,
   fetch_stage_if.master                imem,
   output logic                         if_id_valid,
   output logic [31:0]                  if_id_pc,
   output logic [31:0]                  if_id_instr,
   output logic [$clog2(DEPTH+1)-1:0]   dbg_inflight,
   output logic [$clog2(DEPTH+1)-1:0]   dbg_drop,
   output logic [$clog2(DEPTH+1)-1:0]   dbg_count
);

   localparam int          CW  = $clog2(DEPTH + 1);
   localparam int          PW  = $clog2(DEPTH);
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0]   pc;
   logic [CW-1:0] inflight;
   logic [CW-1:0] drop;
   logic [CW-1:0] count;

   logic [31:0]   pcf [DEPTH];
   logic [PW-1:0] pcf_wr;
   logic [PW-1:0] pcf_rd;

   logic [31:0]   q_pc    [DEPTH];
   logic [31:0]   q_instr [DEPTH];
   logic [PW-1:0] q_wr;
   logic [PW-1:0] q_rd;

   logic [CW:0]   credit_used;
   logic          accept;
   logic          resp;
   logic          resp_keep;
   logic          take;
   logic          pop;
   logic          bypass;
   logic          push;
   logic [31:0]   resp_pc;
   logic [31:0]   target_pc;

   // Every accepted request owns either an in-flight slot or a queue slot.
   assign credit_used         = {1'b0, inflight} + {1'b0, count};
   assign imem.imem_req_valid = !redirect_valid && (credit_used < (CW+1)'(DEPTH));
   assign imem.imem_req_addr  = pc;

   assign accept    = imem.imem_req_valid && imem.imem_req_ready;
   assign resp      = imem.imem_resp_valid;
   assign resp_pc   = pcf[pcf_rd];
   assign target_pc = redirect_pc & ~32'h3;

   // A response into an empty queue goes straight to IF/ID at the same edge.
   assign resp_keep = resp && (drop == '0) && !redirect_valid;
   assign take      = !redirect_valid && !stall;
   assign pop       = take && (count != '0);
   assign bypass    = take && (count == '0) && resp_keep;
   assign push      = resp_keep && !bypass;

   assign dbg_inflight = inflight;
   assign dbg_drop     = drop;
   assign dbg_count    = count;

   always_ff @(posedge clk) begin
      if (accept)
         pcf[pcf_wr] <= pc;
      if (push) begin
         q_pc[q_wr]    <= resp_pc;
         q_instr[q_wr] <= imem.imem_resp_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc       <= RESET_PC;
         inflight <= '0;
         drop     <= '0;
         count    <= '0;
         pcf_wr   <= '0;
         pcf_rd   <= '0;
         q_wr     <= '0;
         q_rd     <= '0;
      end else begin
         inflight <= inflight + CW'(accept) - CW'(resp);
         if (accept)
            pcf_wr <= pcf_wr + PW'(1);
         if (resp)
            pcf_rd <= pcf_rd + PW'(1);
         if (redirect_valid) begin
            pc    <= target_pc;
            drop  <= inflight - CW'(resp);
            count <= '0;
            q_wr  <= '0;
            q_rd  <= '0;
         end else begin
            if (accept)
               pc <= pc + 32'd4;
            if (resp && (drop != '0))
               drop <= drop - CW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (push)
               q_wr <= q_wr + PW'(1);
            if (pop)
               q_rd <= q_rd + PW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_id_valid <= 1'b0;
         if_id_pc    <= 32'h0;
         if_id_instr <= NOP;
      end else if (redirect_valid) begin
         if_id_valid <= 1'b0;
         if_id_pc    <= 32'h0;
         if_id_instr <= NOP;
      end else if (!stall) begin
         if (pop) begin
            if_id_valid <= 1'b1;
            if_id_pc    <= q_pc[q_rd];
            if_id_instr <= q_instr[q_rd];
         end else if (bypass) begin
            if_id_valid <= 1'b1;
            if_id_pc    <= resp_pc;
            if_id_instr <= imem.imem_resp_data;
         end else begin
            if_id_valid <= 1'b0;
            if_id_pc    <= 32'h0;
            if_id_instr <= NOP;
         end
      end
   end

   a_resp_has_request: assert property (@(posedge clk) disable iff (rst)
      imem.imem_resp_valid |-> (inflight != '0));

   a_queue_no_overflow: assert property (@(posedge clk) disable iff (rst)
      (imem.imem_resp_valid && (drop == '0) && !redirect_valid) |-> (count != CW'(DEPTH)));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: behavioural instruction memory with configurable latency,
// in-order stream checking of IF/ID, and hand-computed checks at stall, redirect and reset points.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic [1:0]  dbg_inflight;
   logic [1:0]  dbg_drop;
   logic [1:0]  dbg_count;

   fetch_stage_if ifc ();

   fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem           (ifc),
      .if_id_valid    (if_id_valid),
      .if_id_pc       (if_id_pc),
      .if_id_instr    (if_id_instr),
      .dbg_inflight   (dbg_inflight),
      .dbg_drop       (dbg_drop),
      .dbg_count      (dbg_count)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          mem_lat;
   int          ecount;
   logic [31:0] mq_addr [$];
   int          mq_due  [$];
   logic        cur_acc, last_acc;
   logic [31:0] cur_addr, last_addr;
   logic [31:0] exp_next;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Instructions leave IF/ID when it is valid and neither stalled nor flushed.
   task automatic mon();
      if (!if_id_valid)
         chk("bubble_instr", if_id_instr, 32'h0000_0013);
      else if (!stall && !redirect_valid) begin
         chk("stream_pc", if_id_pc, exp_next);
         chk("stream_instr", if_id_instr, ~exp_next);
         exp_next = exp_next + 32'd4;
      end
      if (redirect_valid)
         exp_next = redirect_pc & ~32'h3;
   endtask

   // Memory returns ~addr, in order, mem_lat cycles after the accepting edge.
   task automatic mem_commit();
      ecount++;
      if (ifc.imem_resp_valid) begin
         void'(mq_addr.pop_front());
         void'(mq_due.pop_front());
      end
      last_acc  = cur_acc;
      last_addr = cur_addr;
      if (cur_acc) begin
         mq_addr.push_back(cur_addr);
         mq_due.push_back(ecount + mem_lat);
      end
      if (mq_addr.size() > 0 && mq_due[0] <= ecount + 1) begin
         ifc.imem_resp_valid = 1'b1;
         ifc.imem_resp_data  = ~mq_addr[0];
      end else begin
         ifc.imem_resp_valid = 1'b0;
         ifc.imem_resp_data  = 32'h0;
      end
   endtask

   task automatic sample();
      #1;
      mon();
      cur_acc  = ifc.imem_req_valid && ifc.imem_req_ready;
      cur_addr = ifc.imem_req_addr;
   endtask

   task automatic step(input logic s, input logic r, input logic [31:0] rpc, input logic rdy);
      @(negedge clk);
      mem_commit();
      stall              = s;
      redirect_valid     = r;
      redirect_pc        = rpc;
      ifc.imem_req_ready = rdy;
      sample();
   endtask

   task automatic do_reset(input int lat);
      rst                 = 1'b1;
      stall               = 1'b0;
      redirect_valid      = 1'b0;
      redirect_pc         = 32'h0;
      ifc.imem_req_ready  = 1'b1;
      ifc.imem_resp_valid = 1'b0;
      ifc.imem_resp_data  = 32'h0;
      mq_addr.delete();
      mq_due.delete();
      cur_acc  = 1'b0;
      last_acc = 1'b0;
      ecount   = 0;
      mem_lat  = lat;
      @(negedge clk);
      @(negedge clk);
      rst      = 1'b0;
      exp_next = 32'h0;
      sample();
   endtask

   initial begin
      stall               = 1'b0;
      redirect_valid      = 1'b0;
      redirect_pc         = 32'h0;
      ifc.imem_req_ready  = 1'b1;
      ifc.imem_resp_valid = 1'b0;
      ifc.imem_resp_data  = 32'h0;
      @(negedge clk);
      #1;
      chk("rst_if_valid", 32'(if_id_valid), 32'd0);
      chk("rst_if_pc", if_id_pc, 32'h0);
      chk("rst_if_instr", if_id_instr, 32'h0000_0013);
      chk("rst_req_addr", ifc.imem_req_addr, 32'h0);
      chk("rst_inflight", 32'(dbg_inflight), 32'd0);

      // Straight-line fetch, 1-cycle memory
      do_reset(1);
      chk("c0_req_valid", 32'(ifc.imem_req_valid), 32'd1);
      chk("c0_req_addr", ifc.imem_req_addr, 32'h0);
      step(0, 0, 0, 1);
      chk("c1_if_valid", 32'(if_id_valid), 32'd0);
      chk("c1_req_addr", ifc.imem_req_addr, 32'h4);
      chk("c1_inflight", 32'(dbg_inflight), 32'd1);
      step(0, 0, 0, 1);
      chk("c2_if_valid", 32'(if_id_valid), 32'd1);
      chk("c2_if_pc", if_id_pc, 32'h0);
      step(0, 0, 0, 1);
      chk("c3_if_pc", if_id_pc, 32'h4);
      for (int i = 4; i <= 6; i++) step(0, 0, 0, 1);

      // Stall for three cycles while streaming
      step(1, 0, 0, 1);
      chk("st7_if_pc", if_id_pc, 32'h14);
      chk("st7_req_valid", 32'(ifc.imem_req_valid), 32'd1);
      step(1, 0, 0, 1);
      chk("st8_if_pc", if_id_pc, 32'h14);
      chk("st8_req_valid", 32'(ifc.imem_req_valid), 32'd0);
      chk("st8_count", 32'(dbg_count), 32'd1);
      step(1, 0, 0, 1);
      chk("st9_if_pc", if_id_pc, 32'h14);
      chk("st9_count", 32'(dbg_count), 32'd2);
      chk("st9_inflight", 32'(dbg_inflight), 32'd0);
      step(0, 0, 0, 1);
      chk("st10_if_pc", if_id_pc, 32'h14);
      chk("st10_req_valid", 32'(ifc.imem_req_valid), 32'd0);
      step(0, 0, 0, 1);
      chk("st11_if_pc", if_id_pc, 32'h18);
      chk("st11_req_addr", ifc.imem_req_addr, 32'h20);
      for (int i = 12; i <= 15; i++) step(0, 0, 0, 1);
      chk("stream_progress", exp_next, 32'h2c);

      // Redirect with a response arriving in the same cycle, stall also high
      step(1, 1, 32'h203, 1);
      chk("rr16_if_pc", if_id_pc, 32'h2c);
      chk("rr16_inflight", 32'(dbg_inflight), 32'd1);
      chk("rr16_req_valid", 32'(ifc.imem_req_valid), 32'd0);
      step(0, 0, 0, 1);
      chk("rr17_if_valid", 32'(if_id_valid), 32'd0);
      chk("rr17_drop", 32'(dbg_drop), 32'd0);
      chk("rr17_inflight", 32'(dbg_inflight), 32'd0);
      chk("rr17_count", 32'(dbg_count), 32'd0);
      chk("rr17_req_addr", ifc.imem_req_addr, 32'h200);
      step(0, 0, 0, 1);
      chk("rr18_if_valid", 32'(if_id_valid), 32'd0);
      step(0, 0, 0, 1);
      chk("rr19_if_valid", 32'(if_id_valid), 32'd1);
      chk("rr19_if_pc", if_id_pc, 32'h200);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

      // Redirect to 0x100 with two requests in flight, 3-cycle memory
      do_reset(3);
      step(0, 0, 0, 1);
      step(0, 1, 32'h100, 1);
      chk("rd2_req_valid", 32'(ifc.imem_req_valid), 32'd0);
      chk("rd2_inflight", 32'(dbg_inflight), 32'd2);
      step(0, 0, 0, 1);
      chk("rd3_drop", 32'(dbg_drop), 32'd2);
      chk("rd3_if_valid", 32'(if_id_valid), 32'd0);
      chk("rd3_req_valid", 32'(ifc.imem_req_valid), 32'd0);
      step(0, 0, 0, 1);
      chk("rd4_drop", 32'(dbg_drop), 32'd1);
      chk("rd4_req_addr", ifc.imem_req_addr, 32'h100);
      chk("rd4_req_valid", 32'(ifc.imem_req_valid), 32'd1);
      step(0, 0, 0, 1);
      chk("rd5_drop", 32'(dbg_drop), 32'd0);
      chk("rd5_inflight", 32'(dbg_inflight), 32'd1);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      chk("rd8_if_valid", 32'(if_id_valid), 32'd1);
      chk("rd8_if_pc", if_id_pc, 32'h100);

      // Backpressure: ready toggles, PC moves only on accept
      for (int i = 0; i < 24; i++) begin
         step(0, 0, 0, (i % 3) != 1);
         chk("bp_req_addr", ifc.imem_req_addr, last_acc ? last_addr + 32'd4 : last_addr);
      end

      // Asynchronous reset mid-stream with two requests in flight
      do_reset(3);
      for (int i = 1; i <= 4; i++) step(0, 0, 0, 1);
      chk("ar4_if_pc", if_id_pc, 32'h0);
      step(1, 0, 0, 1);
      chk("ar5_if_pc", if_id_pc, 32'h4);
      step(1, 0, 0, 1);
      chk("ar6_if_valid", 32'(if_id_valid), 32'd1);
      chk("ar6_inflight", 32'(dbg_inflight), 32'd2);
      chk("ar6_req_addr", ifc.imem_req_addr, 32'h10);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_if_valid", 32'(if_id_valid), 32'd0);
      chk("ar_if_pc", if_id_pc, 32'h0);
      chk("ar_if_instr", if_id_instr, 32'h0000_0013);
      chk("ar_req_addr", ifc.imem_req_addr, 32'h0);
      chk("ar_inflight", 32'(dbg_inflight), 32'd0);
      chk("ar_count", 32'(dbg_count), 32'd0);
      do_reset(3);
      chk("ar0_req_addr", ifc.imem_req_addr, 32'h0);
      chk("ar0_req_valid", 32'(ifc.imem_req_valid), 32'd1);
      for (int i = 1; i <= 4; i++) step(0, 0, 0, 1);
      chk("ar_restart_if_valid", 32'(if_id_valid), 32'd1);
      chk("ar_restart_if_pc", if_id_pc, 32'h0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
